// File: rtl/pc_fetch_unit_pkg.sv
//============================================================================
// Module      : pc_fetch_unit_pkg
// Description : Shared definitions for the PC / instruction fetch unit:
//               FSM state encoding, the NOP instruction placed in the
//               instruction register at reset, and the default reset PC.
// Revision    : 1.0 - initial release
//============================================================================
`default_nettype none

package pc_fetch_unit_pkg;

    // Width of the fetch FSM state register.
    localparam int unsigned c_STATE_W = 2;

    // Fetch FSM states.
    localparam logic [c_STATE_W-1:0] S_IDLE  = 2'd0; // one-cycle start after reset
    localparam logic [c_STATE_W-1:0] S_FETCH = 2'd1; // imem request outstanding
    localparam logic [c_STATE_W-1:0] S_VALID = 2'd2; // instruction held for decode

    // addi x0, x0, 0 -- harmless word presented by the IR before the first fetch.
    localparam logic [31:0] c_NOP_INSTR = 32'h0000_0013;

    // Default address of the first instruction fetched after reset.
    localparam logic [31:0] c_RESET_PC_DEFAULT = 32'h0000_0000;

endpackage : pc_fetch_unit_pkg

`default_nettype wire

// File: rtl/pc_fetch_unit.sv
//============================================================================
// Module      : pc_fetch_unit
// Description : Owns the architectural PC and fetches one instruction per
//               step from instruction memory over a req/ack interface. The
//               fetched word is held in an instruction register until the
//               core consumes it (avanca), at which point the next PC from
//               the next-PC mux (novoPC) is sampled and fetched.
// Revision    : 1.0 - initial release
//
// Ports
//   clk          in   1       clock, rising edge
//   rst          in   1       synchronous reset, active-high
//   novoPC       in   ADDR_W  next PC, sampled only when a step is accepted
//   avanca       in   1       core consumes current instruction
//   halt         in   1       blocks step acceptance while high
//   imem_req     out  1       instruction memory read request
//   imem_addr    out  ADDR_W  read address, stable while imem_req is high
//   imem_ack     in   1       read done, honoured only while fetching
//   imem_rdata   in   DATA_W  read data, valid with imem_ack
//   atualPC      out  ADDR_W  PC of the word held in instr
//   instr        out  DATA_W  instruction register
//   instr_valid  out  1       instr/atualPC hold a fetched instruction
//   instr_count  out  32      number of accepted steps (wraps)
//============================================================================
`default_nettype none

module pc_fetch_unit
    import pc_fetch_unit_pkg::*;
#(
    parameter int unsigned       ADDR_W   = 32,
    parameter int unsigned       DATA_W   = 32,
    parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(c_RESET_PC_DEFAULT)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] novoPC,
    input  logic              avanca,
    input  logic              halt,
    output logic              imem_req,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic              imem_ack,
    input  logic [DATA_W-1:0] imem_rdata,
    output logic [ADDR_W-1:0] atualPC,
    output logic [DATA_W-1:0] instr,
    output logic              instr_valid,
    output logic [31:0]       instr_count
);

    // ------------------------------------------------------------------
    // Registers and their next-state values
    // ------------------------------------------------------------------
    logic [c_STATE_W-1:0] r_state_q;
    logic [c_STATE_W-1:0] w_state_d;
    logic [ADDR_W-1:0]    r_fetch_pc_q;
    logic [ADDR_W-1:0]    w_fetch_pc_d;
    logic [ADDR_W-1:0]    r_atual_pc_q;
    logic [ADDR_W-1:0]    w_atual_pc_d;
    logic [DATA_W-1:0]    r_instr_q;
    logic [DATA_W-1:0]    w_instr_d;
    logic [31:0]          r_count_q;
    logic [31:0]          w_count_d;

    // Qualified events
    logic w_fetch_done;   // memory answered the outstanding request
    logic w_step_accept;  // core consumed the held instruction

    assign w_fetch_done  = (r_state_q == S_FETCH) && imem_ack;
    assign w_step_accept = (r_state_q == S_VALID) && avanca && !halt;

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state_q <= S_IDLE;
        end else begin
            r_state_q <= w_state_d;
        end
    end

    // ------------------------------------------------------------------
    // FSM: next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        w_state_d = r_state_q;
        case (r_state_q)
            S_IDLE:  w_state_d = S_FETCH;
            S_FETCH: if (w_fetch_done)  w_state_d = S_VALID;
            S_VALID: if (w_step_accept) w_state_d = S_FETCH;
            default: w_state_d = S_IDLE;  // unused encoding recovers via a clean restart
        endcase
    end

    // ------------------------------------------------------------------
    // FSM: outputs (Moore, decoded from state only)
    // ------------------------------------------------------------------
    always_comb begin
        imem_req    = 1'b0;
        instr_valid = 1'b0;
        case (r_state_q)
            S_FETCH: imem_req    = 1'b1;
            S_VALID: instr_valid = 1'b1;
            default: ;
        endcase
    end

    // The fetch address register directly drives the memory address, so the
    // address cannot move while a request is outstanding.
    assign imem_addr   = r_fetch_pc_q;
    assign atualPC     = r_atual_pc_q;
    assign instr       = r_instr_q;
    assign instr_count = r_count_q;

    // ------------------------------------------------------------------
    // Datapath next-state: PC, instruction register, retire counter
    // ------------------------------------------------------------------
    always_comb begin
        w_fetch_pc_d = r_fetch_pc_q;
        w_atual_pc_d = r_atual_pc_q;
        w_instr_d    = r_instr_q;
        w_count_d    = r_count_q;

        // Leaving IDLE always begins at the reset vector.
        if (r_state_q == S_IDLE) begin
            w_fetch_pc_d = RESET_PC;
        end

        // IR and atualPC only change on a real answer to our own request;
        // stray acks in other states never reach the IR.
        if (w_fetch_done) begin
            w_instr_d    = imem_rdata;
            w_atual_pc_d = r_fetch_pc_q;
        end

        // novoPC is only meaningful at the moment of a step; wrap is natural.
        if (w_step_accept) begin
            w_fetch_pc_d = novoPC;
            w_count_d    = r_count_q + 32'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_fetch_pc_q <= RESET_PC;
            r_atual_pc_q <= RESET_PC;
            r_instr_q    <= DATA_W'(c_NOP_INSTR);
            r_count_q    <= 32'd0;
        end else begin
            r_fetch_pc_q <= w_fetch_pc_d;
            r_atual_pc_q <= w_atual_pc_d;
            r_instr_q    <= w_instr_d;
            r_count_q    <= w_count_d;
        end
    end

endmodule : pc_fetch_unit

`default_nettype wire

// File: tb/tb_pc_fetch_unit.sv
//============================================================================
// Module      : tb_pc_fetch_unit
// Description : Self-checking bench for pc_fetch_unit. A transaction-level
//               reference (expected fetch PC, held PC/instruction, retired
//               count) is advanced per fetch and per step; memory latency,
//               data and next-PC values are drawn with $urandom.
// Revision    : 1.0 - initial release
//============================================================================
`default_nettype none

module tb_pc_fetch_unit;

    localparam int unsigned c_AW = 32;
    localparam int unsigned c_DW = 32;

    logic            clk;
    logic            rst;
    logic [c_AW-1:0] novoPC;
    logic            avanca;
    logic            halt;
    logic            imem_req;
    logic [c_AW-1:0] imem_addr;
    logic            imem_ack;
    logic [c_DW-1:0] imem_rdata;
    logic [c_AW-1:0] atualPC;
    logic [c_DW-1:0] instr;
    logic            instr_valid;
    logic [31:0]     instr_count;

    pc_fetch_unit #(
        .ADDR_W   (c_AW),
        .DATA_W   (c_DW),
        .RESET_PC (32'h0)
    ) u_dut (
        .clk         (clk),
        .rst         (rst),
        .novoPC      (novoPC),
        .avanca      (avanca),
        .halt        (halt),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_ack    (imem_ack),
        .imem_rdata  (imem_rdata),
        .atualPC     (atualPC),
        .instr       (instr),
        .instr_valid (instr_valid),
        .instr_count (instr_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference state (transaction level)
    logic [c_AW-1:0] exp_pc;     // address of the next/current fetch
    logic [c_AW-1:0] exp_atual;  // PC of the held instruction
    logic [c_DW-1:0] exp_instr;  // held instruction
    logic [31:0]     exp_count;  // retired steps

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    // One memory read answered after 'waits' stall cycles. The core pokes
    // avanca/halt randomly meanwhile; they must be ignored.
    task automatic fetch(input int waits);
        logic [c_DW-1:0] word;
        word = $urandom;
        for (int i = 0; i <= waits; i++) begin
            chk("fetch_req",   64'(imem_req),    64'd1);
            chk("fetch_addr",  64'(imem_addr),   64'(exp_pc));
            chk("fetch_valid", 64'(instr_valid), 64'd0);
            imem_ack   = (i == waits);
            imem_rdata = (i == waits) ? word : c_DW'($urandom);
            avanca     = 1'($urandom_range(0, 1));
            halt       = 1'($urandom_range(0, 1));
            novoPC     = $urandom;
            tick();
        end
        imem_ack  = 1'b0;
        avanca    = 1'b0;
        halt      = 1'b0;
        exp_atual = exp_pc;
        exp_instr = word;
        chk("held_valid", 64'(instr_valid), 64'd1);
        chk("held_req",   64'(imem_req),    64'd0);
        chk("held_pc",    64'(atualPC),     64'(exp_atual));
        chk("held_instr", 64'(instr),       64'(exp_instr));
        chk("held_count", 64'(instr_count), 64'(exp_count));
    endtask

    // Hold the instruction for 'hold' cycles (halt_mode: halt=1 & avanca=1;
    // otherwise avanca=0), optionally with stray acks, then step to 'novo'.
    task automatic step(input int hold, input logic [c_AW-1:0] novo,
                        input bit halt_mode, input bit spur);
        for (int i = 0; i < hold; i++) begin
            halt       = halt_mode ? 1'b1 : 1'($urandom_range(0, 1));
            avanca     = halt_mode;
            imem_ack   = spur;
            imem_rdata = spur ? 32'hDEAD_BEEF : c_DW'($urandom);
            novoPC     = $urandom;
            tick();
            chk("hold_valid", 64'(instr_valid), 64'd1);
            chk("hold_instr", 64'(instr),       64'(exp_instr));
            chk("hold_pc",    64'(atualPC),     64'(exp_atual));
            chk("hold_count", 64'(instr_count), 64'(exp_count));
        end
        imem_ack = 1'b0;
        halt     = 1'b0;
        avanca   = 1'b1;
        novoPC   = novo;
        tick();
        avanca    = 1'b0;
        exp_count = exp_count + 32'd1;
        exp_pc    = novo;
        chk("step_req",   64'(imem_req),    64'd1);
        chk("step_addr",  64'(imem_addr),   64'(exp_pc));
        chk("step_valid", 64'(instr_valid), 64'd0);
        chk("step_count", 64'(instr_count), 64'(exp_count));
    endtask

    task automatic chk_reset_state(input string tag);
        chk({tag, "_req"},   64'(imem_req),    64'd0);
        chk({tag, "_valid"}, 64'(instr_valid), 64'd0);
        chk({tag, "_count"}, 64'(instr_count), 64'd0);
        chk({tag, "_addr"},  64'(imem_addr),   64'd0);
        chk({tag, "_pc"},    64'(atualPC),     64'd0);
        chk({tag, "_instr"}, 64'(instr),       64'h13);
    endtask

    initial begin
        rst        = 1'b1;
        novoPC     = '0;
        avanca     = 1'b0;
        halt       = 1'b0;
        imem_ack   = 1'b0;
        imem_rdata = '0;
        exp_pc     = '0;
        exp_atual  = '0;
        exp_instr  = 32'h13;
        exp_count  = '0;

        // Reset state
        tick();
        tick();
        chk_reset_state("reset");
        rst = 1'b0;
        tick();  // IDLE -> FETCH at RESET_PC

        // Zero-wait memory, sequential stream 0,1,2,3
        fetch(0); step(0, 32'd1, 1'b0, 1'b0);
        fetch(0); step(0, 32'd2, 1'b0, 1'b0);
        fetch(0); step(0, 32'd3, 1'b0, 1'b0);
        chk("count_after_3", 64'(instr_count), 64'd3);

        // Three wait cycles at address 5
        fetch(0); step(0, 32'd5, 1'b0, 1'b0);
        fetch(3);
        chk("wait_pc5", 64'(atualPC), 64'd5);

        // Branch 0x10 -> 0x40
        step(1, 32'h10, 1'b0, 1'b0);
        fetch(1);
        step(0, 32'h40, 1'b0, 1'b0);
        fetch(0);
        chk("branch_pc", 64'(atualPC), 64'h40);

        // halt+avanca for 5 cycles, halt drops, self-loop refetch
        step(5, 32'h40, 1'b1, 1'b0);
        fetch(2);

        // Stray acks with 0xDEADBEEF while valid; step to all-ones then wrap
        step(3, 32'hFFFF_FFFF, 1'b0, 1'b1);
        fetch(0);
        step(2, exp_atual + 32'd1, 1'b1, 1'b1);
        chk("wrap_addr", 64'(imem_addr), 64'd0);
        fetch(1);

        // Randomized stream
        for (int n = 0; n < 25; n++) begin
            step(int'($urandom_range(0, 3)), $urandom,
                 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
            fetch(int'($urandom_range(0, 3)));
        end

        // Reset during a wait state at address 7
        step(0, 32'd7, 1'b0, 1'b0);
        chk("rst_pre_addr", 64'(imem_addr), 64'd7);
        imem_ack = 1'b0;
        tick();
        chk("rst_wait_req", 64'(imem_req), 64'd1);
        rst = 1'b1;
        tick();
        chk_reset_state("midrst");
        rst       = 1'b0;
        exp_pc    = '0;
        exp_atual = '0;
        exp_instr = 32'h13;
        exp_count = '0;
        tick();
        chk("restart_req",  64'(imem_req),  64'd1);
        chk("restart_addr", 64'(imem_addr), 64'd0);
        fetch(0);
        step(0, 32'd1, 1'b0, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule : tb_pc_fetch_unit

`default_nettype wire
